// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use stalls,
// EX-resolved branch flushes, data-memory freeze with watchdog and perf counters.
module hazard_stall_unit #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             rs1_used_id,
   input  logic             rs2_used_id,
   input  logic             DMRd_ex,
   input  logic             RUWr_ex,
   input  logic [4:0]       rd_ex,
   input  logic             NextPCSrc_ex,
   input  logic             dmem_req_me,
   input  logic             dmem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_me,
   output logic             flush_id,
   output logic             bubble_ex,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] load_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_wait_cnt;
   logic             r_timeout;
   logic [CNT_W-1:0] r_lu_cnt;
   logic [CNT_W-1:0] r_fl_cnt;
   logic [CNT_W-1:0] r_mw_cnt;

   logic w_load_use;
   logic w_freeze;
   logic w_flush;
   logic w_lu_stall;
   logic w_wait_entry;
   logic w_wait_inc;
   logic w_to_hit;

   assign w_load_use = DMRd_ex & RUWr_ex & (rd_ex != 5'd0) &
                       ((rs1_used_id & (rs1_id == rd_ex)) |
                        (rs2_used_id & (rs2_id == rd_ex)));

   always_comb begin
      w_state_nxt  = r_state;
      w_freeze     = 1'b0;
      w_wait_entry = 1'b0;
      w_wait_inc   = 1'b0;
      unique case (r_state)
         RUN: begin
            if (dmem_req_me & ~dmem_ready) begin
               w_state_nxt  = MEM_WAIT;
               w_freeze     = 1'b1;
               w_wait_entry = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               w_state_nxt = RUN;
            end else begin
               w_freeze   = 1'b1;
               w_wait_inc = 1'b1;
            end
         end
      endcase
   end

   // Branch squashes the dependent instruction, so load-use is dropped then.
   assign w_flush    = ~w_freeze & NextPCSrc_ex;
   assign w_lu_stall = ~w_freeze & ~NextPCSrc_ex & w_load_use;

   assign w_to_hit = w_wait_inc &
                     (({1'b0, r_wait_cnt} + 17'd1) == 17'(TIMEOUT));

   assign stall_if  = rst_n & (w_freeze | w_lu_stall);
   assign stall_id  = rst_n & (w_freeze | w_lu_stall);
   assign stall_ex  = rst_n & w_freeze;
   assign stall_me  = rst_n & w_freeze;
   assign flush_id  = rst_n & w_flush;
   assign bubble_ex = rst_n & (w_flush | w_lu_stall);

   assign mem_timeout    = r_timeout;
   assign load_stall_cnt = r_lu_cnt;
   assign flush_cnt      = r_fl_cnt;
   assign mem_wait_cnt   = r_mw_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wait_entry) begin
            r_wait_cnt <= '0;
         end else if (w_wait_inc & ~&r_wait_cnt) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
         end
         if (w_to_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Perf counters saturate instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lu_cnt <= '0;
         r_fl_cnt <= '0;
         r_mw_cnt <= '0;
      end else begin
         if (w_lu_stall & ~&r_lu_cnt) begin
            r_lu_cnt <= r_lu_cnt + 1'b1;
         end
         if (w_flush & ~&r_fl_cnt) begin
            r_fl_cnt <= r_fl_cnt + 1'b1;
         end
         if (w_freeze & ~&r_mw_cnt) begin
            r_mw_cnt <= r_mw_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_hazard_stall_unit;

   localparam int CW   = 2;
   localparam int TO   = 4;
   localparam int CMAX = 3;

   logic          clk;
   logic          rst_n;
   logic [4:0]    rs1_id, rs2_id, rd_ex;
   logic          rs1_used_id, rs2_used_id;
   logic          DMRd_ex, RUWr_ex, NextPCSrc_ex;
   logic          dmem_req_me, dmem_ready;
   logic          stall_if, stall_id, stall_ex, stall_me;
   logic          flush_id, bubble_ex, mem_timeout;
   logic [CW-1:0] load_stall_cnt, flush_cnt, mem_wait_cnt;
   logic [6:0]    obs;

   int pass_cnt;
   int total_cnt;

   // reference model state
   bit m_wait;
   int m_wcnt;
   bit m_to;
   int m_lu, m_fl, m_mw;

   hazard_stall_unit #(.CNT_W(CW), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .DMRd_ex(DMRd_ex), .RUWr_ex(RUWr_ex), .rd_ex(rd_ex),
      .NextPCSrc_ex(NextPCSrc_ex),
      .dmem_req_me(dmem_req_me), .dmem_ready(dmem_ready),
      .stall_if(stall_if), .stall_id(stall_id),
      .stall_ex(stall_ex), .stall_me(stall_me),
      .flush_id(flush_id), .bubble_ex(bubble_ex),
      .mem_timeout(mem_timeout),
      .load_stall_cnt(load_stall_cnt),
      .flush_cnt(flush_cnt),
      .mem_wait_cnt(mem_wait_cnt)
   );

   assign obs = {stall_if, stall_id, stall_ex, stall_me,
                 flush_id, bubble_ex, mem_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2,
                        input logic ld, input logic wr,
                        input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
      rs1_id = r1; rs2_id = r2;
      rs1_used_id = u1; rs2_used_id = u2;
      DMRd_ex = ld; RUWr_ex = wr; rd_ex = rd;
      NextPCSrc_ex = br; dmem_req_me = req; dmem_ready = rdy;
   endtask

   task automatic model_reset();
      m_wait = 0; m_wcnt = 0; m_to = 0;
      m_lu = 0; m_fl = 0; m_mw = 0;
   endtask

   function automatic bit m_lu_hit();
      return DMRd_ex && RUWr_ex && rd_ex != 0 &&
             ((rs1_used_id && rs1_id == rd_ex) ||
              (rs2_used_id && rs2_id == rd_ex));
   endfunction

   function automatic bit m_frz();
      return !dmem_ready && (m_wait || dmem_req_me);
   endfunction

   function automatic logic [6:0] model_out();
      logic [6:0] o;
      if (m_frz())           o = 7'b1111000;
      else if (NextPCSrc_ex) o = 7'b0000110;
      else if (m_lu_hit())   o = 7'b1100010;
      else                   o = 7'b0000000;
      o[0] = m_to;
      return o;
   endfunction

   task automatic model_tick();
      if (m_frz())           m_mw = (m_mw < CMAX) ? m_mw + 1 : CMAX;
      else if (NextPCSrc_ex) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
      else if (m_lu_hit())   m_lu = (m_lu < CMAX) ? m_lu + 1 : CMAX;
      if (m_wait) begin
         if (!dmem_ready) begin
            m_wcnt++;
            if (m_wcnt == TO) m_to = 1;
         end else begin
            m_wait = 0;
         end
      end else if (dmem_req_me && !dmem_ready) begin
         m_wait = 1;
         m_wcnt = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      drive(5'd3, 5'd3, 1, 1, 1, 1, 5'd3, 1, 1, 0);
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL reset_outs got %b want 0", obs);
      else pass_cnt++;
      total_cnt++;
      if ({load_stall_cnt, flush_cnt, mem_wait_cnt} !== '0)
         $display("FAIL reset_cnts got %h/%h/%h want 0",
                  load_stall_cnt, flush_cnt, mem_wait_cnt);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge clk);
      drive(5'd1, 5'd5, 1, 1, 1, 1, 5'd5, 0, 0, 1);
      #1;
      total_cnt++;
      if (obs !== 7'b1100010) $display("FAIL lu_stall got %b want 1100010", obs);
      else pass_cnt++;
      total_cnt++;
      if (load_stall_cnt !== 2'd0) $display("FAIL lu_cnt0 got %0d want 0", load_stall_cnt);
      else pass_cnt++;
      @(negedge clk);
      drive(5'd1, 5'd5, 1, 1, 0, 0, 5'd0, 0, 1, 1);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL lu_after got %b want 0", obs);
      else pass_cnt++;
      total_cnt++;
      if (load_stall_cnt !== 2'd1) $display("FAIL lu_cnt1 got %0d want 1", load_stall_cnt);
      else pass_cnt++;
   endtask

   task automatic test_no_hazard();
      do_reset();
      @(negedge clk);
      drive(5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL x0_src got %b want 0", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(5'd1, 5'd5, 1, 0, 1, 1, 5'd5, 0, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL rs2_unused got %b want 0", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(5'd5, 5'd5, 1, 1, 0, 1, 5'd5, 0, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL non_load got %b want 0", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (load_stall_cnt !== 2'd0) $display("FAIL nohaz_cnt got %0d want 0", load_stall_cnt);
      else pass_cnt++;
   endtask

   task automatic test_branch_priority();
      do_reset();
      @(negedge clk);
      drive(5'd7, 5'd2, 1, 1, 1, 1, 5'd7, 1, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0000110) $display("FAIL br_prio got %b want 0000110", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (flush_cnt !== 2'd1 || load_stall_cnt !== 2'd0)
         $display("FAIL br_cnts got fl=%0d lu=%0d want fl=1 lu=0",
                  flush_cnt, load_stall_cnt);
      else pass_cnt++;
      // freeze outranks both branch and load-use
      @(negedge clk);
      drive(5'd7, 5'd2, 1, 1, 1, 1, 5'd7, 1, 1, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b1111000) $display("FAIL frz_prio got %b want 1111000", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         #1;
         total_cnt++;
         if (obs !== 7'b1111000) $display("FAIL mw_frz%0d got %b want 1111000", i, obs);
         else pass_cnt++;
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL mw_release got %b want 0", obs);
      else pass_cnt++;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (mem_wait_cnt !== 2'd3) $display("FAIL mw_cnt got %0d want 3", mem_wait_cnt);
      else pass_cnt++;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL mw_run got %b want 0", obs);
      else pass_cnt++;
      // single-cycle access never freezes
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL mw_1cyc got %b want 0", obs);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         #1;
         total_cnt++;
         if (obs !== {6'b111100, (i >= TO + 1) ? 1'b1 : 1'b0})
            $display("FAIL to_wait%0d got %b want %b", i, obs,
                     {6'b111100, (i >= TO + 1) ? 1'b1 : 1'b0});
         else pass_cnt++;
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0000001) $display("FAIL to_sticky got %b want 0000001", obs);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (obs !== 7'b0 || {load_stall_cnt, flush_cnt, mem_wait_cnt} !== '0)
         $display("FAIL to_rst got %b cnts %h/%h/%h want all 0", obs,
                  load_stall_cnt, flush_cnt, mem_wait_cnt);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL to_rst_run got %b want 0", obs);
      else pass_cnt++;
   endtask

   task automatic test_flush_sat();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total_cnt++;
      if (flush_cnt !== 2'd3) $display("FAIL fl_sat got %0d want 3", flush_cnt);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [6:0] exp_o;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom_range(0, 3) == 0));
         #1;
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            total_cnt++;
            if (obs !== 7'b0 || {load_stall_cnt, flush_cnt, mem_wait_cnt} !== '0)
               $display("FAIL rnd_rst%0d got %b want 0", n, obs);
            else pass_cnt++;
         end else begin
            exp_o = model_out();
            total_cnt++;
            if (obs !== exp_o)
               $display("FAIL rnd_out%0d got %b want %b", n, obs, exp_o);
            else pass_cnt++;
            total_cnt++;
            if (load_stall_cnt !== CW'(m_lu) || flush_cnt !== CW'(m_fl) ||
                mem_wait_cnt !== CW'(m_mw))
               $display("FAIL rnd_cnt%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                        n, load_stall_cnt, flush_cnt, mem_wait_cnt,
                        m_lu, m_fl, m_mw);
            else pass_cnt++;
            model_tick();
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_flush_sat();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline. It complements the ME/WB bypass logic by handling the hazards that bypassing cannot hide:
  - load-use dependencies: stall IF/ID for one cycle and insert a bubble into EX;
  - taken branches/jumps resolved in EX: flush ID and EX;
  - data-memory wait states: freeze the whole pipeline.
- Holds a memory-wait FSM, a timeout watchdog and saturating performance counters.

Parameters:
- CNT_W, 32: width of each performance counter.
- TIMEOUT, 255: maximum MEM_WAIT cycles before mem_timeout is raised. Legal range 1..2^16-1.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_id  in  5  rs1 of the instruction in ID.
- rs2_id  in  5  rs2 of the instruction in ID.
- rs1_used_id  in  1  ID instruction reads rs1.
- rs2_used_id  in  1  ID instruction reads rs2.
- DMRd_ex  in  1  EX instruction is a load.
- RUWr_ex  in  1  EX instruction writes the register file.
- rd_ex  in  5  destination register of the EX instruction.
- NextPCSrc_ex  in  1  taken branch/jump resolved in EX this cycle.
- dmem_req_me  in  1  ME stage accesses data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold the IF/ID register.
- stall_ex  out  1  hold the ID/EX register.
- stall_me  out  1  hold the EX/ME and ME/WB registers.
- flush_id  out  1  clear the IF/ID register to a NOP.
- bubble_ex  out  1  load a NOP into ID/EX.
- mem_timeout  out  1  sticky error flag.
- load_stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of flush cycles.
- mem_wait_cnt  out  CNT_W  number of freeze cycles.

Behaviour:
- Reset:
  - rst_n low: state=RUN, wait counter=0, mem_timeout=0, all perf counters=0.
  - All stall/flush/bubble outputs are forced to 0 while rst_n is low.
  - Reset asserted mid-MEM_WAIT aborts the wait immediately; no counter increments.
- Hazard terms (all combinational, same cycle as the inputs):
  - load_use = DMRd_ex & RUWr_ex & (rd_ex≠0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
  - freeze = (state==RUN & dmem_req_me & ~dmem_ready) | (state==MEM_WAIT & ~dmem_ready).
- Priority: freeze > flush > load_use.
  - freeze: stall_if=stall_id=stall_ex=stall_me=1; flush_id=bubble_ex=0. Branch/load-use are deferred, because the inputs are held stable by the freeze.
  - else NextPCSrc_ex: flush_id=1, bubble_ex=1, no stalls. Load-use is dropped, since the dependent instruction is squashed.
  - else load_use: stall_if=stall_id=1, bubble_ex=1, stall_ex=stall_me=0. This lasts exactly 1 cycle; the load then moves to ME and the condition clears.
  - else all outputs 0.
- FSM, states RUN and MEM_WAIT:
  - RUN→MEM_WAIT when dmem_req_me & ~dmem_ready.
  - MEM_WAIT→RUN on the first cycle dmem_ready=1. freeze=0 in that cycle (zero-latency release).
  - dmem_ready=1 in RUN with a request means a single-cycle access: no freeze, stay in RUN.
- Watchdog:
  - 16-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When the counter reaches TIMEOUT, mem_timeout is set. It is registered, visible the next cycle, and sticky until reset.
  - The freeze continues after timeout.
- Perf counters:
  - Registered, +1 on each cycle the corresponding output condition is active: load-use stall, flush, freeze.
  - Saturate at 2^CNT_W-1; no wrap.
- x0 is never a hazard source.
- No ME/WB bypass cases produce stalls.

Test Plan:
- lw x5 in EX (DMRd_ex=1, RUWr_ex=1, rd_ex=5), ID add with rs2_id=5, rs2_used_id=1 → 1 cycle of stall_if=stall_id=bubble_ex=1; load_stall_cnt 0→1; outputs 0 on the next cycle.
- Same as above but rd_ex=0, or rs2_used_id=0 → no stall; load_stall_cnt stays 0.
- Load-use and NextPCSrc_ex=1 in the same cycle → flush_id=bubble_ex=1, stall_if=0; flush_cnt=1, load_stall_cnt=0.
- dmem_req_me=1, dmem_ready low for 3 cycles then high → all four stalls high for exactly 3 cycles; release on the ready cycle; mem_wait_cnt=3; FSM back in RUN.
- TIMEOUT=4, dmem_ready held low for 10 cycles → mem_timeout rises after the 4th wait cycle and stays 1 after ready. rst_n pulse mid-wait → all outputs/counters 0 and state RUN.
- CNT_W=2, 5 consecutive flush cycles → flush_cnt saturates at 3.
